// File: rtl/unidade_controle_exp7_pkg.sv
// rtl/unidade_controle_exp7_pkg.sv - shared game constants and controller state encodings
// Purpose: datapath sizing constants shared by the memory-game slice, plus the
//          controller state type so db_estado decodes identically everywhere.
// Ports:   none (package).
package unidade_controle_exp7_pkg;

    // Datapath sizing: 4-bit plays, 16-entry sequence memory.
    localparam int DATA_W    = 4;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        MOSTRA        = 4'h3,
        PROX_MOSTRA   = 4'h4,
        FIM_MOSTRA    = 4'h5,
        ESPERA        = 4'h6,
        REGISTRA      = 4'h7,
        COMPARA       = 4'h8,
        PROX_JOGADA   = 4'h9,
        PROX_RODADA   = 4'hA,
        FIM_ACERTOU   = 4'hB,
        FIM_ERROU     = 4'hC,
        FIM_TIMEOUT   = 4'hD
    } estado_t;

endpackage

// File: rtl/unidade_controle_exp7_if.sv
// rtl/unidade_controle_exp7_if.sv - controller <-> datapath signal bundle
// Purpose: groups the status inputs and control/status outputs of the game
//          controller so the controller and datapath connect as one port.
// Ports:   master = controller side (drives controls/status, reads datapath flags);
//          slave  = datapath/environment side (mirror image).
interface unidade_controle_exp7_if;

    // datapath / user flags into the controller
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualSequencia;
    logic       fimS;
    logic       fimL;
    logic       fimTMR;

    // datapath controls out of the controller
    logic       zeraE;
    logic       contaE;
    logic       zeraS;
    logic       contaS;
    logic       zeraR;
    logic       registraR;
    logic       zeraL;
    logic       contaL;
    logic       zeraTMR;
    logic       contaTMR;
    logic       ativa_leds;

    // game-end status and debug
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualSequencia, fimS, fimL, fimTMR,
        output zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraL, contaL,
               zeraTMR, contaTMR, ativa_leds, pronto, acertou, errou, timeout,
               db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualSequencia, fimS, fimL, fimTMR,
        input  zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraL, contaL,
               zeraTMR, contaTMR, ativa_leds, pronto, acertou, errou, timeout,
               db_estado
    );

endinterface

// File: rtl/unidade_controle_exp7.sv
// rtl/unidade_controle_exp7.sv - Moore control unit for the sequence memory game
// Purpose: sequences a round (show stored plays on LEDs, then collect and compare
//          the player's presses) and reports win / wrong play / timeout.
// Ports:   clock - system clock, rising edge
//          reset - synchronous active-high reset to INICIAL
//          bus   - master modport: datapath flags in, counter/register controls,
//                  ativa_leds, game-end status and db_estado out
module unidade_controle_exp7
    import unidade_controle_exp7_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_exp7_if.master bus
);

    estado_t state_q;
    estado_t state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore output decode; every output depends on state_q only.
    always_comb begin
        state_d        = state_q;
        bus.zeraE      = 1'b0;
        bus.contaE     = 1'b0;
        bus.zeraS      = 1'b0;
        bus.contaS     = 1'b0;
        bus.zeraR      = 1'b0;
        bus.registraR  = 1'b0;
        bus.zeraL      = 1'b0;
        bus.contaL     = 1'b0;
        bus.zeraTMR    = 1'b0;
        bus.contaTMR   = 1'b0;
        bus.ativa_leds = 1'b0;
        bus.pronto     = 1'b0;
        bus.acertou    = 1'b0;
        bus.errou      = 1'b0;
        bus.timeout    = 1'b0;

        case (state_q)
            INICIAL: begin
                if (bus.iniciar) state_d = PREPARA;
            end
            PREPARA: begin
                bus.zeraE   = 1'b1;
                bus.zeraS   = 1'b1;
                bus.zeraR   = 1'b1;
                bus.zeraL   = 1'b1;
                bus.zeraTMR = 1'b1;
                state_d     = INICIO_RODADA;
            end
            INICIO_RODADA: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                state_d   = MOSTRA;
            end
            MOSTRA: begin
                bus.ativa_leds = 1'b1;
                bus.contaL     = 1'b1;
                if (bus.fimL) begin
                    state_d = bus.enderecoIgualSequencia ? FIM_MOSTRA : PROX_MOSTRA;
                end
            end
            PROX_MOSTRA: begin
                bus.contaE = 1'b1;
                bus.zeraL  = 1'b1;
                state_d    = MOSTRA;
            end
            FIM_MOSTRA: begin
                bus.zeraE   = 1'b1;
                bus.zeraTMR = 1'b1;
                state_d     = ESPERA;
            end
            ESPERA: begin
                bus.contaTMR = 1'b1;
                // A press in the same cycle the timer expires still counts.
                if (bus.jogada)      state_d = REGISTRA;
                else if (bus.fimTMR) state_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                bus.registraR = 1'b1;
                state_d       = COMPARA;
            end
            COMPARA: begin
                if (!bus.igual)                       state_d = FIM_ERROU;
                else if (!bus.enderecoIgualSequencia) state_d = PROX_JOGADA;
                else if (bus.fimS)                    state_d = FIM_ACERTOU;
                else                                  state_d = PROX_RODADA;
            end
            PROX_JOGADA: begin
                bus.contaE  = 1'b1;
                bus.zeraTMR = 1'b1;
                state_d     = ESPERA;
            end
            PROX_RODADA: begin
                bus.contaS = 1'b1;
                state_d    = INICIO_RODADA;
            end
            FIM_ACERTOU: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
                if (bus.iniciar) state_d = PREPARA;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
                if (bus.iniciar) state_d = PREPARA;
            end
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
                if (bus.iniciar) state_d = PREPARA;
            end
            // Unused encodings E/F recover to INICIAL with outputs idle.
            default: state_d = INICIAL;
        endcase
    end

    assign bus.db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// tb/tb_unidade_controle_exp7.sv - self-checking bench for unidade_controle_exp7
module tb_unidade_controle_exp7;

    logic clock = 1'b0;
    logic reset;

    unidade_controle_exp7_if ifc ();

    unidade_controle_exp7 dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Output bit positions within the packed output word.
    localparam int O_ZE = 14, O_CE = 13, O_ZS = 12, O_CS = 11, O_ZR = 10, O_RR = 9,
                   O_ZL = 8, O_CL = 7, O_ZT = 6, O_CT = 5, O_AL = 4, O_PR = 3,
                   O_AC = 2, O_ER = 1, O_TO = 0;

    // Reference: game step rules stated per named phase.
    function automatic int ref_next(int s, logic rst, logic ini, logic jog, logic ig,
                                    logic eq, logic fs, logic fl, logic ft);
        if (rst) return 0;
        case (s)
            0:          return ini ? 1 : 0;
            1:          return 2;
            2:          return 3;
            3:          return !fl ? 3 : (eq ? 5 : 4);
            4:          return 3;
            5:          return 6;
            6:          return jog ? 7 : (ft ? 13 : 6);
            7:          return 8;
            8:          return !ig ? 12 : (!eq ? 9 : (fs ? 11 : 10));
            9:          return 6;
            10:         return 2;
            11, 12, 13: return ini ? 1 : s;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [14:0] ref_outs(int s);
        logic [14:0] o;
        o = '0;
        case (s)
            1:  begin o[O_ZE]=1; o[O_ZS]=1; o[O_ZR]=1; o[O_ZL]=1; o[O_ZT]=1; end
            2:  begin o[O_ZE]=1; o[O_ZL]=1; end
            3:  begin o[O_AL]=1; o[O_CL]=1; end
            4:  begin o[O_CE]=1; o[O_ZL]=1; end
            5:  begin o[O_ZE]=1; o[O_ZT]=1; end
            6:  o[O_CT] = 1;
            7:  o[O_RR] = 1;
            9:  begin o[O_CE]=1; o[O_ZT]=1; end
            10: o[O_CS] = 1;
            11: begin o[O_PR]=1; o[O_AC]=1; end
            12: begin o[O_PR]=1; o[O_ER]=1; end
            13: begin o[O_PR]=1; o[O_TO]=1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic logic [14:0] dut_outs();
        return {ifc.zeraE, ifc.contaE, ifc.zeraS, ifc.contaS, ifc.zeraR, ifc.registraR,
                ifc.zeraL, ifc.contaL, ifc.zeraTMR, ifc.contaTMR, ifc.ativa_leds,
                ifc.pronto, ifc.acertou, ifc.errou, ifc.timeout};
    endfunction

    int m_state = 0;

    always @(posedge clock) begin
        m_state <= ref_next(m_state, reset, ifc.iniciar, ifc.jogada, ifc.igual,
                            ifc.enderecoIgualSequencia, ifc.fimS, ifc.fimL, ifc.fimTMR);
    end

    // Per-cycle comparison against the reference, away from the active edge.
    always @(negedge clock) begin
        vectors++;
        if (ifc.db_estado !== 4'(m_state) || dut_outs() !== ref_outs(m_state)) begin
            miscompares++;
            $display("FAIL model t=%0t state act=%h req=%h outs act=%b req=%b",
                     $time, ifc.db_estado, m_state, dut_outs(), ref_outs(m_state));
        end
    end

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Inputs {rst,ini,jog,ig,eq,fs,fl,ft} held across one rising edge; returns at falling edge.
    task automatic step(input logic [7:0] v);
        {reset, ifc.iniciar, ifc.jogada, ifc.igual, ifc.enderecoIgualSequencia,
         ifc.fimS, ifc.fimL, ifc.fimTMR} = v;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    int n_leds;
    int n_conta;

    initial begin
        step(8'b1000_0000);
        chk("reset_state", ifc.db_estado, 0);
        chk("reset_outs", dut_outs(), 0);

        // Round 1 with fimS=1 and a correct play: 0,1,2,3,5,6,7,8,B.
        step(8'b0100_0000); chk("r1_prepara", ifc.db_estado, 1);
        step(8'b0000_0000); chk("r1_inicio", ifc.db_estado, 2);
        step(8'b0000_0000); chk("r1_mostra", ifc.db_estado, 3);
        chk("r1_leds", ifc.ativa_leds, 1);
        step(8'b0000_1110); chk("r1_fim_mostra", ifc.db_estado, 5);
        step(8'b0000_0000); chk("r1_espera", ifc.db_estado, 6);
        step(8'b0010_0000); chk("r1_registra", ifc.db_estado, 7);
        step(8'b0000_0000); chk("r1_compara", ifc.db_estado, 8);
        step(8'b0001_1100); chk("r1_acertou", ifc.db_estado, 11);
        chk("r1_pronto_acertou", {ifc.pronto, ifc.acertou, ifc.errou, ifc.timeout}, 4'b1100);

        // jogada/iniciar ignored where not meaningful; then restart.
        step(8'b0010_0000); chk("fim_hold", ifc.db_estado, 11);
        step(8'b0100_0000); chk("fim_restart", ifc.db_estado, 1);

        // Round showing three words: LEDs on in three MOSTRA visits, two contaE pulses.
        step(8'b0000_0000);
        n_leds = 0; n_conta = 0;
        for (int i = 0; i < 3; i++) begin
            step(8'b0000_0000);
            n_leds += int'(ifc.ativa_leds);
            step(i == 2 ? 8'b0000_1010 : 8'b0000_0010);
            n_conta += int'(ifc.contaE);
        end
        chk("show_leds_count", n_leds, 3);
        chk("show_contaE_count", n_conta, 2);
        step(8'b0010_0000); chk("show_espera", ifc.db_estado, 6);

        // Timeout, then restart.
        step(8'b0000_0001); chk("timeout_state", ifc.db_estado, 13);
        chk("timeout_flags", {ifc.pronto, ifc.timeout}, 2'b11);
        step(8'b0100_0000); chk("timeout_restart", ifc.db_estado, 1);

        // Press and timer expiry together: play wins, then wrong play.
        step(8'b0000_0000); step(8'b0000_0000);
        step(8'b0000_1010); step(8'b0000_0000);
        chk("both_espera", ifc.db_estado, 6);
        step(8'b0010_0001); chk("both_registra", ifc.db_estado, 7);
        step(8'b0000_0000);
        step(8'b0000_1100); chk("errou_state", ifc.db_estado, 12);
        chk("errou_flag", ifc.errou, 1);

        // Next round path, and reset mid-game from ESPERA.
        step(8'b0100_0000); step(8'b0000_0000); step(8'b0000_0000);
        step(8'b0000_1010); step(8'b0000_0000); step(8'b0010_0000); step(8'b0000_0000);
        step(8'b0001_1000); chk("prox_rodada", ifc.db_estado, 10);
        chk("prox_rodada_contaS", ifc.contaS, 1);
        step(8'b0000_0000); chk("after_prox_rodada", ifc.db_estado, 2);
        chk("contaS_one_cycle", ifc.contaS, 0);
        step(8'b0000_0000); step(8'b0000_1010); step(8'b0000_0000);
        chk("pre_reset_espera", ifc.db_estado, 6);
        step(8'b1010_0001); chk("reset_from_espera", ifc.db_estado, 0);
        chk("reset_from_espera_outs", dut_outs(), 0);

        // Random phase, checked every cycle by the reference process.
        for (int i = 0; i < 4000; i++) begin
            step({ ($urandom_range(99) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(3) == 0),  ($urandom_range(4) != 0),
                   ($urandom_range(1) == 0),  ($urandom_range(2) == 0),
                   ($urandom_range(2) == 0),  ($urandom_range(7) == 0) });
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidade_controle_exp7.md
UNIDADE_CONTROLE_EXP7 -- requirements
Module: unidade_controle_exp7

Interface
REQ-001 Module SHALL have no parameters; all encodings come from the shared package.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iniciar  in  1  start/restart request, level-sampled.
REQ-005 jogada  in  1  one-cycle pulse from datapath: button press detected.
REQ-006 igual  in  1  registered play equals memory word.
REQ-007 enderecoIgualSequencia  in  1  address counter E equals round counter S.
REQ-008 fimS  in  1  round counter S at last round.
REQ-009 fimL  in  1  LED-display timer expired.
REQ-010 fimTMR  in  1  play-timeout timer expired.
REQ-011 zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraL, contaL, zeraTMR, contaTMR  out  1 each  datapath counter/register controls.
REQ-012 ativa_leds  out  1  gates memory word onto leds.
REQ-013 pronto, acertou, errou, timeout  out  1 each  game-end status.
REQ-014 db_estado  out  4  current state encoding.

Function
REQ-015 Controller SHALL be Moore: every output decodes from current state only; unlisted outputs are 0 in each state.
REQ-016 States/encodings: INICIAL 0, PREPARA 1, INICIO_RODADA 2, MOSTRA 3, PROX_MOSTRA 4, FIM_MOSTRA 5, ESPERA 6, REGISTRA 7, COMPARA 8, PROX_JOGADA 9, PROX_RODADA A, FIM_ACERTOU B, FIM_ERROU C, FIM_TIMEOUT D.
REQ-017 INICIAL: iniciar -> PREPARA, else hold.
REQ-018 PREPARA: zeraE, zeraS, zeraR, zeraL, zeraTMR = 1 -> INICIO_RODADA.
REQ-019 INICIO_RODADA: zeraE, zeraL = 1 -> MOSTRA.
REQ-020 MOSTRA: ativa_leds, contaL = 1; fimL & !enderecoIgualSequencia -> PROX_MOSTRA; fimL & enderecoIgualSequencia -> FIM_MOSTRA; else hold.
REQ-021 PROX_MOSTRA: contaE, zeraL = 1 -> MOSTRA.
REQ-022 FIM_MOSTRA: zeraE, zeraTMR = 1 -> ESPERA.
REQ-023 ESPERA: contaTMR = 1; jogada -> REGISTRA; !jogada & fimTMR -> FIM_TIMEOUT; jogada wins when both same cycle.
REQ-024 REGISTRA: registraR = 1 -> COMPARA.
REQ-025 COMPARA: !igual -> FIM_ERROU; igual & !enderecoIgualSequencia -> PROX_JOGADA; igual & enderecoIgualSequencia & fimS -> FIM_ACERTOU; igual & enderecoIgualSequencia & !fimS -> PROX_RODADA.
REQ-026 PROX_JOGADA: contaE, zeraTMR = 1 -> ESPERA.
REQ-027 PROX_RODADA: contaS = 1 -> INICIO_RODADA.
REQ-028 FIM_ACERTOU/FIM_ERROU/FIM_TIMEOUT: pronto = 1 plus acertou/errou/timeout respectively; iniciar -> PREPARA, else hold.
REQ-029 Encodings E, F SHALL go to INICIAL next cycle with all outputs 0.
REQ-030 jogada outside ESPERA SHALL be ignored; iniciar outside INICIAL and FIM_* states SHALL be ignored.

Reset
REQ-031 reset high at a rising edge SHALL force INICIAL, from any state, mid-game included; reset has priority over all inputs.
REQ-032 In INICIAL every output SHALL be 0 and db_estado = 4'h0.

Structure
REQ-033 State encodings SHALL live in a shared package alongside the existing datapath constants.
REQ-034 No sub-module; state register, next-state logic and output decode in this module only.

Verification
REQ-035 Reset in ESPERA -> db_estado 0 next edge, all outputs 0.
REQ-036 Round 1, fimS=1, correct play -> states 0,1,2,3,5,6,7,8,B; pronto=acertou=1.
REQ-037 Round with E reaching S after 3 fimL pulses -> ativa_leds high in three MOSTRA visits, contaE pulsed 2 times, then ESPERA.
REQ-038 ESPERA, fimTMR=1, jogada=0 -> FIM_TIMEOUT (D), pronto=timeout=1; then iniciar=1 -> PREPARA.
REQ-039 ESPERA, jogada=fimTMR=1 same cycle -> REGISTRA (7), not D; igual=0 in COMPARA -> FIM_ERROU (C), errou=1.
REQ-040 COMPARA, igual=1, enderecoIgualSequencia=1, fimS=0 -> PROX_RODADA (A), contaS=1 one cycle, then INICIO_RODADA.
